stack_lifo: RTL and testbench

- Parametrised LIFO stack; successor to the fixed 2-bit stack.
- Generalises data width and depth.
- Adds: simultaneous push+pop (replace-top), occupancy count, almost-full threshold, sticky overflow/underflow error flags, synchronous flush.
- Used as an operand/return-address store by sequencing logic in the same clock domain.

---
 rtl/stack_lifo.sv | 111 +++++++++++
 tb/tb_stack_lifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/stack_lifo.sv
//------------------------------------------------------------------------------
// Module   : stack_lifo
// Brief    : Parametrised LIFO stack with replace-top, occupancy, sticky errors
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stack_lifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [CW-1:0]    count_m1;
  logic             is_full, is_empty;

  assign count_m1 = count_q - CW'(1);
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = '0;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            waddr   = count_q[AW-1:0];
            count_d = count_q + CW'(1);
          end
        end
        2'b01: begin
          if (is_empty) unf_d = 1'b1;
          else          count_d = count_m1;
        end
        2'b11: begin
          // Empty push+pop still pushes, but the pop half is an error.
          we = 1'b1;
          if (is_empty) begin
            waddr   = '0;
            count_d = CW'(1);
            unf_d   = 1'b1;
          end else begin
            waddr = count_m1[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && we) mem_q[waddr] <= data_in_i;
  end

  assign data_out_o    = is_empty ? '0 : mem_q[count_m1[AW-1:0]];
  assign count_o       = count_q;
  assign full_o        = is_full;
  assign empty_o       = is_empty;
  assign almost_full_o = (count_q >= CW'(AF_LEVEL));
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_lifo.sv
//------------------------------------------------------------------------------
// Module   : tb_stack_lifo
// Brief    : Directed vector table plus randomized run against a queue model
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_lifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, push, pop, clear;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             full, empty, afull, ovf, unf;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [WIDTH-1:0] mq[$];
  bit               m_ovf, m_unf;

  typedef struct {
    bit         r, p, o, c;
    logic [7:0] d;
    int         e_cnt;
    logic [7:0] e_dout;
    bit         e_full, e_empty, e_af, e_ovf, e_unf;
  } vec_t;

  vec_t vq[$];

  stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop), .clear_i(clear),
    .data_in_i(din), .data_out_o(dout), .count_o(count), .full_o(full),
    .empty_o(empty), .almost_full_o(afull), .overflow_o(ovf),
    .underflow_o(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  // Reference: the stack is a queue whose back is the top.
  task automatic model(input bit r, input bit p, input bit o, input bit c, input logic [7:0] d);
    if (r || c) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (p && o) begin
      if (mq.size() == 0) begin
        mq.push_back(d);
        m_unf = 1;
      end else begin
        mq[mq.size()-1] = d;
      end
    end else if (p) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(d);
    end else if (o) begin
      if (mq.size() == 0) m_unf = 1;
      else void'(mq.pop_back());
    end
  endtask

  task automatic step(input bit r, input bit p, input bit o, input bit c, input logic [7:0] d);
    rst = r; push = p; pop = o; clear = c; din = d;
    @(posedge clk);
    model(r, p, o, c, d);
    cyc++;
    #1;
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("count", count, sz);
    chk("data_out", dout, (sz == 0) ? 0 : mq[sz-1]);
    chk("full", full, sz == DEPTH);
    chk("empty", empty, sz == 0);
    chk("almost_full", afull, sz >= AFL);
    chk("overflow", ovf, m_ovf);
    chk("underflow", unf, m_unf);
  endtask

  task automatic add(input bit r, p, o, c, input logic [7:0] d, input int cnt,
                     input logic [7:0] dv, input bit f, e, a, ov, un);
    vq.push_back('{r, p, o, c, d, cnt, dv, f, e, a, ov, un});
  endtask

  initial begin
    rst = 1; push = 0; pop = 0; clear = 0; din = '0;

    //   r p o c  din    cnt dout  full empty af ovf unf
    add(1,0,0,0, 8'h00, 0, 8'h00, 0,1,0,0,0);
    add(0,1,0,0, 8'h11, 1, 8'h11, 0,0,0,0,0);
    add(0,1,0,0, 8'h22, 2, 8'h22, 0,0,0,0,0);
    add(0,1,0,0, 8'h33, 3, 8'h33, 0,0,1,0,0);
    add(0,1,0,0, 8'h44, 4, 8'h44, 1,0,1,0,0);
    add(0,1,0,0, 8'h55, 4, 8'h44, 1,0,1,1,0);
    add(0,0,1,0, 8'h00, 3, 8'h33, 0,0,1,1,0);
    add(0,0,1,0, 8'h00, 2, 8'h22, 0,0,0,1,0);
    add(0,0,1,0, 8'h00, 1, 8'h11, 0,0,0,1,0);
    add(0,0,1,0, 8'h00, 0, 8'h00, 0,1,0,1,0);
    add(0,0,1,0, 8'h00, 0, 8'h00, 0,1,0,1,1);
    add(0,0,0,1, 8'h00, 0, 8'h00, 0,1,0,0,0);
    add(0,1,1,0, 8'hA5, 1, 8'hA5, 0,0,0,0,1);
    add(0,0,0,1, 8'h00, 0, 8'h00, 0,1,0,0,0);
    add(0,1,0,0, 8'h11, 1, 8'h11, 0,0,0,0,0);
    add(0,1,0,0, 8'h22, 2, 8'h22, 0,0,0,0,0);
    add(0,1,1,0, 8'h99, 2, 8'h99, 0,0,0,0,0);
    add(0,0,1,0, 8'h00, 1, 8'h11, 0,0,0,0,0);
    add(0,1,0,0, 8'h22, 2, 8'h22, 0,0,0,0,0);
    add(0,1,0,0, 8'h33, 3, 8'h33, 0,0,1,0,0);
    add(0,1,0,0, 8'h44, 4, 8'h44, 1,0,1,0,0);
    add(0,1,1,0, 8'h99, 4, 8'h99, 1,0,1,0,0);
    add(0,0,1,0, 8'h00, 3, 8'h33, 0,0,1,0,0);
    add(0,1,0,0, 8'h55, 4, 8'h55, 1,0,1,0,0);
    add(0,1,0,0, 8'h66, 4, 8'h55, 1,0,1,1,0);
    add(0,0,1,0, 8'h00, 3, 8'h33, 0,0,1,1,0);
    add(0,1,0,1, 8'h77, 0, 8'h00, 0,1,0,0,0);
    add(0,1,0,0, 8'h11, 1, 8'h11, 0,0,0,0,0);
    add(0,1,0,0, 8'h22, 2, 8'h22, 0,0,0,0,0);
    add(1,1,0,0, 8'h88, 0, 8'h00, 0,1,0,0,0);
    add(0,0,1,1, 8'h00, 0, 8'h00, 0,1,0,0,0);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].p, vq[i].o, vq[i].c, vq[i].d);
      chk("vec_count", count, vq[i].e_cnt);
      chk("vec_data_out", dout, vq[i].e_dout);
      chk("vec_full", full, vq[i].e_full);
      chk("vec_empty", empty, vq[i].e_empty);
      chk("vec_almost_full", afull, vq[i].e_af);
      chk("vec_overflow", ovf, vq[i].e_ovf);
      chk("vec_underflow", unf, vq[i].e_unf);
    end

    // Random phase alternates push-heavy and pop-heavy windows.
    for (int k = 0; k < 2000; k++) begin
      int pp, po;
      bit r, p, o, c;
      pp = ((k / 100) % 2 == 0) ? 65 : 35;
      po = 100 - pp;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 49) == 0);
      p = ($urandom_range(0, 99) < pp);
      o = ($urandom_range(0, 99) < po);
      step(r, p, o, c, 8'($urandom));
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
